rr_arbiter_hold: RTL and testbench

Parametrised N-way round-robin arbiter with registered one-hot grant, grant hold (lock) while the owner keeps requesting, and a bounded tenure (MAX_HOLD) that forces rotation when others wait.
Sits at each crossbar output port and selects which input channel drives the port. Successor to the 4-way combinational-grant arbiter.

---
 rtl/rr_pkg.sv | 17 +
 rtl/rr_pick.sv | 32 +++
 rtl/rr_arbiter_hold.sv | 118 +++++++++++
 tb/tb_rr_arbiter_hold.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_pkg.sv
// Shared arbitration types and width helpers for crossbar port allocators.
package rr_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Bit width needed to hold values 0..value-1, never less than one bit.
    function automatic int unsigned clog2_min1(input int unsigned value);
        int unsigned w;
        w = $clog2(value);
        if (w < 1) w = 1;
        return w;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set candidate bit at or after ptr, wrapping.
module rr_pick
    import rr_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = clog2_min1(N)
) (
    input  logic [N-1:0]     cand,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        int unsigned j;
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        j      = 0;
        for (int unsigned k = 0; k < N; k++) begin
            j = 32'(ptr) + k;
            if (j >= N) j = j - N;
            if (!any && cand[IDX_W'(j)]) begin
                onehot[IDX_W'(j)] = 1'b1;
                idx               = IDX_W'(j);
                any               = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter_hold.sv
// N-way round-robin arbiter with registered grant, ownership hold while requesting,
// and a MAX_HOLD tenure limit that rotates ownership when others are waiting.
module rr_arbiter_hold
    import rr_pkg::*;
#(
    parameter  int unsigned N        = 4,
    parameter  int unsigned MAX_HOLD = 8,
    localparam int unsigned IDX_W    = clog2_min1(N),
    localparam int unsigned CNT_W    = clog2_min1(MAX_HOLD + 1)
) (
    input  logic             clk,
    input  logic             rst_in,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             expire
);

    state_t             state, state_n;
    logic [N-1:0]       gnt_n;
    logic [IDX_W-1:0]   idx_n;
    logic               valid_n;
    logic               expire_n;
    logic [IDX_W-1:0]   ptr, ptr_n;
    logic [CNT_W-1:0]   cnt, cnt_n;

    logic [N-1:0]       cand;
    logic [N-1:0]       pick_onehot;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic               owner_req;
    logic               others_req;
    logic               expiry;

    assign owner_req  = |(req & gnt);
    assign others_req = |(req & ~gnt);
    assign expiry     = (state == GRANT) && (MAX_HOLD != 0) && owner_req &&
                        (cnt == CNT_W'(MAX_HOLD)) && others_req;
    // On expiry the current owner is excluded so the grant must move on.
    assign cand       = expiry ? (req & ~gnt) : req;

    rr_pick #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_pick (
        .cand   (cand),
        .ptr    (ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_n  = state;
        gnt_n    = gnt;
        idx_n    = gnt_idx;
        valid_n  = gnt_valid;
        expire_n = 1'b0;
        ptr_n    = ptr;
        cnt_n    = cnt;

        case (state)
            IDLE: begin
                if (pick_any) begin
                    state_n = GRANT;
                    gnt_n   = pick_onehot;
                    idx_n   = pick_idx;
                    valid_n = 1'b1;
                    cnt_n   = CNT_W'(1);
                    ptr_n   = (pick_idx == IDX_W'(N - 1)) ? '0 : pick_idx + IDX_W'(1);
                end
            end
            GRANT: begin
                if (!owner_req || expiry) begin
                    if (pick_any) begin
                        gnt_n    = pick_onehot;
                        idx_n    = pick_idx;
                        valid_n  = 1'b1;
                        cnt_n    = CNT_W'(1);
                        ptr_n    = (pick_idx == IDX_W'(N - 1)) ? '0 : pick_idx + IDX_W'(1);
                        expire_n = expiry;
                    end else begin
                        state_n = IDLE;
                        gnt_n   = '0;
                        idx_n   = '0;
                        valid_n = 1'b0;
                        cnt_n   = '0;
                    end
                end else if ((MAX_HOLD != 0) && (cnt < CNT_W'(MAX_HOLD))) begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            expire    <= 1'b0;
            ptr       <= '0;
            cnt       <= '0;
        end else begin
            state     <= state_n;
            gnt       <= gnt_n;
            gnt_idx   <= idx_n;
            gnt_valid <= valid_n;
            expire    <= expire_n;
            ptr       <= ptr_n;
            cnt       <= cnt_n;
        end
    end

endmodule

// File: tb/tb_rr_arbiter_hold.sv
// Bench for rr_arbiter_hold: directed scenarios plus a randomized run against an
// integer-level model of owner, pointer and tenure.
module tb_rr_arbiter_hold;

    localparam int N  = 4;
    localparam int MH = 3;
    localparam int WAIT_BOUND = (N - 1) * MH + 1;

    logic       clk = 1'b0;
    logic       rst_in;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       expire;

    logic [2:0] req3;
    logic [2:0] gnt3;
    logic [1:0] gnt_idx3;
    logic       gnt_valid3;
    logic       expire3;

    int total = 0;
    int bad   = 0;

    int m_owner;
    int m_ptr;
    int m_cnt;
    bit m_exp;

    always #5 clk = ~clk;

    rr_arbiter_hold #(.N(4), .MAX_HOLD(3)) dut (
        .clk       (clk),
        .rst_in    (rst_in),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .expire    (expire)
    );

    rr_arbiter_hold #(.N(3), .MAX_HOLD(0)) dut3 (
        .clk       (clk),
        .rst_in    (rst_in),
        .req       (req3),
        .gnt       (gnt3),
        .gnt_idx   (gnt_idx3),
        .gnt_valid (gnt_valid3),
        .expire    (expire3)
    );

    function automatic int pick(input logic [3:0] c, input int p);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (p + k) % N;
            if (c[j]) return j;
        end
        return -1;
    endfunction

    function automatic logic [3:0] m_gnt();
        logic [3:0] v;
        v = 4'b0000;
        if (m_owner >= 0) v[m_owner] = 1'b1;
        return v;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_cnt   = 0;
        m_exp   = 1'b0;
    endtask

    task automatic model_grant(input int w);
        m_owner = w;
        m_ptr   = (w + 1) % N;
        m_cnt   = 1;
    endtask

    // One clock edge of the arbitration rules, applied to the request seen at that edge.
    task automatic model_step(input logic [3:0] r);
        int w;
        logic [3:0] others;
        m_exp = 1'b0;
        if (m_owner < 0) begin
            w = pick(r, m_ptr);
            if (w >= 0) model_grant(w);
        end else if (!r[m_owner]) begin
            w = pick(r, m_ptr);
            if (w >= 0) model_grant(w);
            else m_owner = -1;
        end else begin
            others = r & ~m_gnt();
            if (m_cnt == MH && others != 4'b0000) begin
                model_grant(pick(others, m_ptr));
                m_exp = 1'b1;
            end else if (m_cnt < MH) begin
                m_cnt = m_cnt + 1;
            end
        end
    endtask

    task automatic tick(input logic [3:0] r);
        req = r;
        @(posedge clk);
        model_step(r);
        #1;
    endtask

    task automatic tick3(input logic [2:0] r);
        req3 = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        req    = 4'b0000;
        req3   = 3'b000;
        @(posedge clk);
        #1;
        rst_in = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
        total++; if (gnt_idx !== 2'd0) begin bad++; $display("FAIL reset_idx: got %0d expected 0", gnt_idx); end
        total++; if (gnt_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b expected 0", gnt_valid); end
        total++; if (expire !== 1'b0) begin bad++; $display("FAIL reset_expire: got %b expected 0", expire); end
        tick(4'b0110);
        total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL first_gnt: got %b expected 0010", gnt); end
        total++; if (gnt_idx !== 2'd1) begin bad++; $display("FAIL first_idx: got %0d expected 1", gnt_idx); end
        total++; if (gnt_valid !== 1'b1) begin bad++; $display("FAIL first_valid: got %b expected 1", gnt_valid); end
        // Owner 1 releases; pointer at 2 must prefer 2 over 0.
        tick(4'b0101);
        total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL ptr_after_first: got %b expected 0100", gnt); end
        #2 rst_in = 1'b1;
        #1;
        total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL async_rst_gnt: got %b expected 0000", gnt); end
        total++; if (gnt_valid !== 1'b0) begin bad++; $display("FAIL async_rst_valid: got %b expected 0", gnt_valid); end
        total++; if (gnt_idx !== 2'd0) begin bad++; $display("FAIL async_rst_idx: got %0d expected 0", gnt_idx); end
        #1 rst_in = 1'b0;
        req = 4'b0000;
        model_reset();
    endtask

    task automatic test_rotation();
        do_reset();
        for (int t = 1; t <= 16; t++) begin
            int o;
            logic [3:0] eg;
            logic ee;
            o  = ((t - 1) / MH) % N;
            eg = 4'b0001 << o;
            ee = (t > 1) && ((t - 1) % MH == 0);
            tick(4'b1111);
            total++; if (gnt !== eg) begin bad++; $display("FAIL rot_gnt[%0d]: got %b expected %b", t, gnt, eg); end
            total++; if (gnt_idx !== 2'(o)) begin bad++; $display("FAIL rot_idx[%0d]: got %0d expected %0d", t, gnt_idx, o); end
            total++; if (expire !== ee) begin bad++; $display("FAIL rot_expire[%0d]: got %b expected %b", t, expire, ee); end
        end
    endtask

    task automatic test_release_handoff();
        do_reset();
        tick(4'b0010);
        total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL ho_own1: got %b expected 0010", gnt); end
        tick(4'b0010);
        tick(4'b0100);
        total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL ho_move: got %b expected 0100", gnt); end
        total++; if (expire !== 1'b0) begin bad++; $display("FAIL ho_expire: got %b expected 0", expire); end
        tick(4'b0000);
        total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL ho_idle_gnt: got %b expected 0000", gnt); end
        total++; if (gnt_valid !== 1'b0) begin bad++; $display("FAIL ho_idle_valid: got %b expected 0", gnt_valid); end
    endtask

    task automatic test_sole_requester();
        do_reset();
        for (int t = 0; t < 10; t++) begin
            tick(4'b0001);
            total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL sole_gnt[%0d]: got %b expected 0001", t, gnt); end
            total++; if (expire !== 1'b0) begin bad++; $display("FAIL sole_expire[%0d]: got %b expected 0", t, expire); end
        end
        tick(4'b0101);
        total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL sole_preempt: got %b expected 0100", gnt); end
        total++; if (expire !== 1'b1) begin bad++; $display("FAIL sole_preempt_exp: got %b expected 1", expire); end
    endtask

    task automatic test_wrap();
        do_reset();
        tick(4'b0100);
        total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL wrap_g2: got %b expected 0100", gnt); end
        tick(4'b1001);
        total++; if (gnt !== 4'b1000) begin bad++; $display("FAIL wrap_g3: got %b expected 1000", gnt); end
        tick(4'b0001);
        total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL wrap_g0: got %b expected 0001", gnt); end
        tick(4'b0000);

        // Three requesters, unlimited hold.
        tick3(3'b100);
        total++; if (gnt3 !== 3'b100 || gnt_idx3 !== 2'd2) begin bad++; $display("FAIL n3_first: got %b/%0d expected 100/2", gnt3, gnt_idx3); end
        for (int t = 0; t < 20; t++) begin
            tick3(3'b111);
            total++; if (gnt3 !== 3'b100 || expire3 !== 1'b0) begin bad++; $display("FAIL n3_hold[%0d]: got %b exp=%b expected 100 exp=0", t, gnt3, expire3); end
        end
        tick3(3'b011);
        total++; if (gnt3 !== 3'b001 || gnt_idx3 !== 2'd0) begin bad++; $display("FAIL n3_to0: got %b/%0d expected 001/0", gnt3, gnt_idx3); end
        tick3(3'b010);
        total++; if (gnt3 !== 3'b010 || gnt_idx3 !== 2'd1) begin bad++; $display("FAIL n3_to1: got %b/%0d expected 010/1", gnt3, gnt_idx3); end
        for (int t = 0; t < 5; t++) tick3(3'b111);
        tick3(3'b101);
        total++; if (gnt3 !== 3'b100 || gnt_idx3 !== 2'd2) begin bad++; $display("FAIL n3_to2: got %b/%0d expected 100/2", gnt3, gnt_idx3); end
        tick3(3'b001);
        total++; if (gnt3 !== 3'b001 || gnt_idx3 !== 2'd0) begin bad++; $display("FAIL n3_wrap0: got %b/%0d expected 001/0", gnt3, gnt_idx3); end
        total++; if (gnt_valid3 !== 1'b1) begin bad++; $display("FAIL n3_valid: got %b expected 1", gnt_valid3); end
        tick3(3'b000);
    endtask

    task automatic test_random();
        logic [3:0] r;
        logic [3:0] prev_gnt;
        int burst [4];
        int waits [4];
        do_reset();
        r = 4'b0000;
        for (int i = 0; i < N; i++) begin burst[i] = 0; waits[i] = 0; end
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!r[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        r[i]     = 1'b1;
                        burst[i] = $urandom_range(1, 6);
                    end
                end else if (burst[i] == 0) begin
                    r[i] = 1'b0;
                end
            end
            prev_gnt = gnt;
            tick(r);
            if (m_owner >= 0 && burst[m_owner] > 0) burst[m_owner]--;
            total++; if (gnt !== m_gnt()) begin bad++; $display("FAIL rnd_gnt[%0d]: got %b expected %b", c, gnt, m_gnt()); end
            total++; if (gnt_idx !== ((m_owner < 0) ? 2'd0 : 2'(m_owner))) begin bad++; $display("FAIL rnd_idx[%0d]: got %0d expected owner %0d", c, gnt_idx, m_owner); end
            total++; if (gnt_valid !== (m_owner >= 0)) begin bad++; $display("FAIL rnd_valid[%0d]: got %b expected %b", c, gnt_valid, m_owner >= 0); end
            total++; if (expire !== m_exp) begin bad++; $display("FAIL rnd_expire[%0d]: got %b expected %b", c, expire, m_exp); end
            total++; if (!$onehot0(gnt)) begin bad++; $display("FAIL rnd_onehot[%0d]: got %b expected zero or one-hot", c, gnt); end
            total++; if (expire === 1'b1 && gnt === prev_gnt) begin bad++; $display("FAIL rnd_exp_change[%0d]: got gnt %b unchanged expected owner change", c, gnt); end
            for (int i = 0; i < N; i++) begin
                if (r[i] && !gnt[i]) waits[i]++;
                else waits[i] = 0;
                total++; if (waits[i] > WAIT_BOUND) begin bad++; $display("FAIL rnd_wait[%0d][%0d]: got %0d cycles expected <= %0d", c, i, waits[i], WAIT_BOUND); end
            end
        end
        tick(4'b0000);
    endtask

    initial begin
        rst_in = 1'b1;
        req    = 4'b0000;
        req3   = 3'b000;
        model_reset();
        test_reset();
        test_rotation();
        test_release_handoff();
        test_sole_requester();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
